// File: rtl/commit_trace_fifo.sv
// Commit-trace capture: taps GPR (W stage) and DM (M stage) writes in program order
// and buffers them in a FIFO drained through a valid/ready port.
module commit_trace_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FILTER_R0 = 1,
  parameter int unsigned SEQ_W     = 16,
  parameter int unsigned DROP_W    = 16,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gpr_wr,
  input  logic [4:0]        gpr_waddr,
  input  logic [31:0]       gpr_wd,
  input  logic [31:0]       instr_w,
  input  logic              dm_wr,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_din,
  input  logic [31:0]       instr_m,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic              trc_type,
  output logic [SEQ_W-1:0]  trc_seq,
  output logic [31:0]       trc_instr,
  output logic [31:0]       trc_addr,
  output logic [31:0]       trc_data,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_ovf
);

  localparam int unsigned DSUM_W = DROP_W + 1;

  typedef struct packed {
    logic             typ;
    logic [SEQ_W-1:0] seq;
    logic [31:0]      instr;
    logic [31:0]      addr;
    logic [31:0]      data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             g_ent;
  entry_t             d_ent;

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [SEQ_W-1:0]   seq_q;
  logic               valid_q;
  logic               ovf_q;
  logic [DROP_W-1:0]  drop_q;

  logic               e_g;
  logic               push_g;
  logic               push_d;
  logic               pop;
  logic [CNT_W-1:0]   space;
  logic [CNT_W-1:0]   n_push;
  logic [1:0]         n_drop;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   d_slot;
  logic [DROP_W-1:0]  drop_base;
  logic [DSUM_W-1:0]  drop_sum;
  logic [DROP_W-1:0]  drop_nxt;

  // Event qualification and admission; space is taken before any same-cycle pop.
  always_comb begin
    e_g       = gpr_wr & ~((FILTER_R0 != 0) & (gpr_waddr == 5'd0));
    space     = CNT_W'(DEPTH) - count_q;
    push_g    = e_g & (space != '0);
    push_d    = dm_wr & (space >= (e_g ? CNT_W'(2) : CNT_W'(1)));
    pop       = valid_q & trc_ready;
    n_push    = CNT_W'(push_g) + CNT_W'(push_d);
    n_drop    = 2'(e_g & ~push_g) + 2'(dm_wr & ~push_d);
    count_nxt = count_q + n_push - CNT_W'(pop);
    d_slot    = wr_ptr_q + PTR_W'(push_g);
  end

  // GPR write is older than the coincident DM write, so it takes the lower seq.
  always_comb begin
    g_ent.typ   = 1'b0;
    g_ent.seq   = seq_q;
    g_ent.instr = instr_w;
    g_ent.addr  = {27'b0, gpr_waddr};
    g_ent.data  = gpr_wd;
    d_ent.typ   = 1'b1;
    d_ent.seq   = seq_q + SEQ_W'(e_g);
    d_ent.instr = instr_m;
    d_ent.addr  = dm_addr;
    d_ent.data  = dm_din;
  end

  // Saturating drop counter; a drop in the same cycle overrides clear.
  always_comb begin
    drop_base = clr_ovf ? '0 : drop_q;
    drop_sum  = {1'b0, drop_base} + DSUM_W'(n_drop);
    drop_nxt  = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_nxt;
      seq_q    <= seq_q + SEQ_W'(e_g) + SEQ_W'(dm_wr);
      valid_q  <= (count_nxt != '0);
      if (n_drop != 2'd0) begin
        ovf_q  <= 1'b1;
        drop_q <= drop_nxt;
      end else if (clr_ovf) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_g) mem[wr_ptr_q] <= g_ent;
    if (push_d) mem[d_slot]   <= d_ent;
  end

  assign head      = mem[rd_ptr_q];
  assign trc_valid = valid_q;
  assign trc_type  = head.typ;
  assign trc_seq   = head.seq;
  assign trc_instr = head.instr;
  assign trc_addr  = head.addr;
  assign trc_data  = head.data;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
